// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C register-transaction sequencer: master command codes,
// response status codes, transaction phases and per-command sub-states.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        CMD_START   = 3'b000,
        CMD_WR      = 3'b001,
        CMD_RD      = 3'b010,
        CMD_STOP    = 3'b011,
        CMD_RESTART = 3'b100
    } i2c_cmd_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_NACK    = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_e;

    typedef enum logic [3:0] {
        PH_IDLE, PH_START, PH_DEVW, PH_REG, PH_WDATA,
        PH_RSTART, PH_DEVR, PH_RDATA, PH_STOP, PH_RESP
    } phase_e;

    typedef enum logic [1:0] {
        SUB_ISSUE, SUB_GAP, SUB_WAIT
    } sub_e;

    // The single read byte is the last one, so the master answers it with NACK.
    localparam logic [7:0] RD_LAST_DIN = 8'h01;

    function automatic i2c_cmd_e phase_cmd(input phase_e ph);
        i2c_cmd_e c;
        case (ph)
            PH_START:  c = CMD_START;
            PH_RSTART: c = CMD_RESTART;
            PH_RDATA:  c = CMD_RD;
            PH_STOP:   c = CMD_STOP;
            default:   c = CMD_WR;
        endcase
        return c;
    endfunction

    function automatic logic phase_is_byte(input phase_e ph);
        return ph inside {PH_DEVW, PH_REG, PH_WDATA, PH_DEVR, PH_RDATA};
    endfunction

    function automatic phase_e phase_succ(input phase_e ph, input logic rw);
        phase_e n;
        case (ph)
            PH_START:  n = PH_DEVW;
            PH_DEVW:   n = PH_REG;
            PH_REG:    n = rw ? PH_RSTART : PH_WDATA;
            PH_WDATA:  n = PH_STOP;
            PH_RSTART: n = PH_DEVR;
            PH_DEVR:   n = PH_RDATA;
            PH_RDATA:  n = PH_STOP;
            PH_STOP:   n = PH_RESP;
            default:   n = PH_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/i2c_xact_seq_if.sv
// Host request/response port plus byte-level I2C master handshake, bundled.
// The master modport is the sequencer's view; slave is the surrounding system.
interface i2c_xact_seq_if;
    import i2c_seq_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [7:0]  req_wdata;

    logic        rsp_valid;
    rsp_status_e rsp_status;
    logic [7:0]  rsp_rdata;

    i2c_cmd_e    m_cmd;
    logic [7:0]  m_din;
    logic        m_wr_i2c;
    logic        m_ready;
    logic        m_done_tick;
    logic        m_ack;
    logic [7:0]  m_dout;

    modport master (
        input  req_valid, req_rw, req_dev, req_reg, req_wdata,
        output req_ready,
        output rsp_valid, rsp_status, rsp_rdata,
        output m_cmd, m_din, m_wr_i2c,
        input  m_ready, m_done_tick, m_ack, m_dout
    );

    modport slave (
        output req_valid, req_rw, req_dev, req_reg, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_status, rsp_rdata,
        input  m_cmd, m_din, m_wr_i2c,
        output m_ready, m_done_tick, m_ack, m_dout
    );

endinterface

// File: rtl/i2c_wdog.sv
// Per-command watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle that brings the total to LIMIT. Saturates, never wraps.
module i2c_wdog #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] SAT  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != SAT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // count_reg holds cycles already spent, so the current cycle is number count_reg+1.
    assign expire = en && (count_reg >= LAST);

endmodule

// File: rtl/i2c_xact_seq.sv
// Register read/write sequencer: expands one host request into the START/WR/
// RESTART/RD/STOP command stream for a byte-level I2C master and reports status.
module i2c_xact_seq
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    i2c_xact_seq_if.master bus
);
    phase_e      phase_reg, phase_next;
    sub_e        sub_reg, sub_next;
    logic        rw_reg;
    logic [6:0]  dev_reg;
    logic [7:0]  regad_reg, wdata_reg;
    logic        seen_reg, seen_next;
    logic        ack_reg, ack_next;
    logic [7:0]  cap_reg, cap_next;
    logic        nack_reg, nack_next;
    rsp_status_e rsp_status_reg, rsp_status_next;
    logic [7:0]  rsp_rdata_reg, rsp_rdata_next;

    logic        accept, wd_clr, wd_en, wd_expire;
    logic        wr_phase, byte_done, nack_now;
    logic [7:0]  cur_din;

    i2c_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    assign wd_en     = (phase_reg != PH_IDLE) && (phase_reg != PH_RESP);
    assign wr_phase  = phase_is_byte(phase_reg) && (phase_reg != PH_RDATA);
    assign byte_done = seen_reg || bus.m_done_tick;
    assign nack_now  = wr_phase && (bus.m_done_tick ? bus.m_ack : ack_reg);

    assign bus.req_ready  = (phase_reg == PH_IDLE);
    assign bus.rsp_valid  = (phase_reg == PH_RESP);
    assign bus.rsp_status = rsp_status_reg;
    assign bus.rsp_rdata  = rsp_rdata_reg;

    always_comb begin
        cur_din = 8'h00;
        case (phase_reg)
            PH_DEVW:  cur_din = {dev_reg, 1'b0};
            PH_REG:   cur_din = regad_reg;
            PH_WDATA: cur_din = wdata_reg;
            PH_DEVR:  cur_din = {dev_reg, 1'b1};
            PH_RDATA: cur_din = RD_LAST_DIN;
            default:  cur_din = 8'h00;
        endcase
    end

    always_comb begin
        phase_next      = phase_reg;
        sub_next        = sub_reg;
        seen_next       = seen_reg;
        ack_next        = ack_reg;
        cap_next        = cap_reg;
        nack_next       = nack_reg;
        rsp_status_next = rsp_status_reg;
        rsp_rdata_next  = rsp_rdata_reg;
        accept          = 1'b0;
        wd_clr          = 1'b0;
        bus.m_cmd       = CMD_START;
        bus.m_din       = 8'h00;
        bus.m_wr_i2c    = 1'b0;

        case (phase_reg)
            PH_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    phase_next = PH_START;
                    sub_next   = SUB_ISSUE;
                    nack_next  = 1'b0;
                    wd_clr     = 1'b1;
                end
            end
            PH_RESP: phase_next = PH_IDLE;
            default: begin
                // A tick seen in GAP is as good as one seen in WAIT.
                if ((sub_reg != SUB_ISSUE) && bus.m_done_tick) begin
                    seen_next = 1'b1;
                    ack_next  = bus.m_ack;
                    if (phase_reg == PH_RDATA) cap_next = bus.m_dout;
                end
                case (sub_reg)
                    SUB_ISSUE: begin
                        bus.m_cmd    = phase_cmd(phase_reg);
                        bus.m_din    = cur_din;
                        bus.m_wr_i2c = bus.m_ready && !wd_expire;
                        if (bus.m_ready) begin
                            sub_next  = SUB_GAP;
                            seen_next = 1'b0;
                        end
                    end
                    SUB_GAP: sub_next = SUB_WAIT;
                    default: begin
                        if (bus.m_ready && (!phase_is_byte(phase_reg) || byte_done)) begin
                            wd_clr   = 1'b1;
                            sub_next = SUB_ISSUE;
                            if (phase_reg == PH_STOP) begin
                                phase_next      = PH_RESP;
                                rsp_status_next = nack_reg ? RSP_NACK : RSP_OK;
                                rsp_rdata_next  = (rw_reg && !nack_reg) ? cap_reg : 8'h00;
                            end else if (nack_now) begin
                                phase_next = PH_STOP;
                                nack_next  = 1'b1;
                            end else begin
                                phase_next = phase_succ(phase_reg, rw_reg);
                            end
                        end
                    end
                endcase
                // A stuck master gets no STOP; report straight away.
                if (wd_expire) begin
                    phase_next      = PH_RESP;
                    sub_next        = SUB_ISSUE;
                    rsp_status_next = RSP_TIMEOUT;
                    rsp_rdata_next  = 8'h00;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg      <= PH_IDLE;
            sub_reg        <= SUB_ISSUE;
            seen_reg       <= 1'b0;
            ack_reg        <= 1'b0;
            cap_reg        <= 8'h00;
            nack_reg       <= 1'b0;
            rsp_status_reg <= RSP_OK;
            rsp_rdata_reg  <= 8'h00;
            rw_reg         <= 1'b0;
            dev_reg        <= 7'h00;
            regad_reg      <= 8'h00;
            wdata_reg      <= 8'h00;
        end else begin
            phase_reg      <= phase_next;
            sub_reg        <= sub_next;
            seen_reg       <= seen_next;
            ack_reg        <= ack_next;
            cap_reg        <= cap_next;
            nack_reg       <= nack_next;
            rsp_status_reg <= rsp_status_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            if (accept) begin
                rw_reg    <= bus.req_rw;
                dev_reg   <= bus.req_dev;
                regad_reg <= bus.req_reg;
                wdata_reg <= bus.req_wdata;
            end
        end
    end

endmodule
